mul_div_unit: RTL

Iterative RV32M multiply/divide unit sitting directly downstream of `register_file`. It consumes `RFdata1`/`RFdata2` as operands and produces a 32-bit result that the writeback path routes back into `RFwrite_data`. The unit is multi-cycle: the control path stalls the PC and holds `RFwenable` low while `MDbusy` is high, and the write happens in the cycle `MDdone` is high.

---
 rtl/md_pkg.sv | 41 ++++
 rtl/mul_div_unit_if.sv | 31 +++
 rtl/mul_div_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
// Shared definitions for the iterative RV32M multiply/divide unit:
//   - RV32M funct3 encodings (MD_MUL .. MD_REMU)
//   - FSM state type (IDLE, CALC, FIX, DONE)
//   - iteration count and fixed results for the division special cases
//   - helpers that tell which operands are treated as signed for an op
// ---------------------------------------------------------------------------
package md_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam int          MD_ITER   = 32;
    localparam logic [31:0] MD_DIVZ_Q = 32'hFFFFFFFF;
    localparam logic [31:0] MD_OVF_Q  = 32'h80000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    // rs1 is signed for every op except the fully unsigned ones
    function automatic logic mdSignedA(input logic [2:0] op);
        return !(op == MD_MULHU || op == MD_DIVU || op == MD_REMU);
    endfunction

    // rs2 is signed only for MUL, MULH, DIV and REM
    function automatic logic mdSignedB(input logic [2:0] op);
        return (op == MD_MUL || op == MD_MULH || op == MD_DIV || op == MD_REM);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// ---------------------------------------------------------------------------
// mul_div_unit_if
// Request/response bundle between the control path and the mul/div unit.
//   MDstart  : request a new operation (master -> slave)
//   MDop     : RV32M funct3 (master -> slave)
//   MDa/MDb  : rs1/rs2 operands (master -> slave)
//   MDbusy   : unit is not idle (slave -> master)
//   MDdone   : one-cycle pulse, MDresult valid (slave -> master)
//   MDresult : registered result (slave -> master)
// ---------------------------------------------------------------------------
interface mul_div_unit_if #(
    parameter int XLEN = 32
);
    logic            MDstart;
    logic [2:0]      MDop;
    logic [XLEN-1:0] MDa;
    logic [XLEN-1:0] MDb;
    logic            MDbusy;
    logic            MDdone;
    logic [XLEN-1:0] MDresult;

    modport master (
        output MDstart, MDop, MDa, MDb,
        input  MDbusy, MDdone, MDresult
    );

    modport slave (
        input  MDstart, MDop, MDa, MDb,
        output MDbusy, MDdone, MDresult
    );
endinterface

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes,
// processed for 32 cycles in a shared 64-bit shift register (shift-add
// multiply or restoring divide), then signs are reapplied in a FIX cycle.
// Division by zero and signed overflow are resolved directly from IDLE.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   md  : mul_div_unit_if slave (MDstart/MDop/MDa/MDb in,
//         MDbusy/MDdone/MDresult out)
// ---------------------------------------------------------------------------
module mul_div_unit
    import md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic            clk,
    input logic            rst,
    mul_div_unit_if.slave  md
);

    md_state_e         state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opB_q, opB_d;
    logic              negRes_q, negRes_d;
    logic              negRem_q, negRem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              aNeg, bNeg;
    logic [XLEN-1:0]   magA, magB;
    logic              divZero, divOvf;
    logic [XLEN-1:0]   specialRes;
    logic [XLEN:0]     mulSum;
    logic [XLEN:0]     divDiff;
    logic [2*XLEN-1:0] prodFix;
    logic [XLEN-1:0]   fixRes;

    // Decode of the incoming request: operand signs, magnitudes and the
    // division special cases that bypass the iterative datapath.
    always_comb begin
        aNeg       = mdSignedA(md.MDop) & md.MDa[XLEN-1];
        bNeg       = mdSignedB(md.MDop) & md.MDb[XLEN-1];
        magA       = aNeg ? (~md.MDa + 1'b1) : md.MDa;
        magB       = bNeg ? (~md.MDb + 1'b1) : md.MDb;
        divZero    = md.MDop[2] && (md.MDb == '0);
        divOvf     = (md.MDop == MD_DIV || md.MDop == MD_REM) &&
                     (md.MDa == MD_OVF_Q) && (md.MDb == '1);
        specialRes = '0;
        if (divZero) begin
            specialRes = md.MDop[1] ? md.MDa : MD_DIVZ_Q;
        end else begin
            specialRes = md.MDop[1] ? '0 : MD_OVF_Q;
        end
    end

    // One iteration of each algorithm. The multiply adds the multiplicand
    // into the upper half when the current multiplier bit is set, then
    // shifts right keeping the carry. The divide shifts the
    // {remainder, quotient} pair left; the 33-bit trial subtraction covers
    // the bit that moves out of the remainder.
    always_comb begin
        mulSum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                  {1'b0, (acc_q[0] ? opB_q : {XLEN{1'b0}})};
        divDiff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opB_q};
    end

    // Sign correction and result selection for the FIX state. The remainder
    // follows the dividend sign, the quotient and product follow sign XOR.
    always_comb begin
        prodFix = negRes_q ? (~acc_q + 1'b1) : acc_q;
        fixRes  = '0;
        if (!op_q[2]) begin
            fixRes = (op_q == MD_MUL) ? prodFix[XLEN-1:0] : prodFix[2*XLEN-1:XLEN];
        end else if (!op_q[1]) begin
            fixRes = negRes_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        end else begin
            fixRes = negRem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        end
    end

    // Main FSM: accept in IDLE, iterate in CALC, sign-fix in FIX and pulse
    // done in DONE. Requests arriving outside IDLE are dropped.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opB_d    = opB_q;
        negRes_d = negRes_q;
        negRem_d = negRem_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (md.MDstart) begin
                    op_d  = md.MDop;
                    cnt_d = '0;
                    if (divZero || divOvf) begin
                        result_d = specialRes;
                        state_d  = ST_DONE;
                    end else begin
                        acc_d    = {{XLEN{1'b0}}, magA};
                        opB_d    = magB;
                        negRes_d = aNeg ^ bNeg;
                        negRem_d = aNeg;
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (!op_q[2]) begin
                    acc_d = {mulSum, acc_q[XLEN-1:1]};
                end else if (!divDiff[XLEN]) begin
                    acc_d = {divDiff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(MD_ITER - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d = fixRes;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            opB_q    <= '0;
            negRes_q <= 1'b0;
            negRem_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opB_q    <= opB_d;
            negRes_q <= negRes_d;
            negRem_q <= negRem_d;
            result_q <= result_d;
        end
    end

    assign md.MDbusy   = (state_q != ST_IDLE);
    assign md.MDdone   = (state_q == ST_DONE);
    assign md.MDresult = result_q;

endmodule
